// File: rtl/mult_share_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : mult_share_sched_if
//  Description : Operand request, multiplier and result bus bundle for
//                mult_share_sched. The slave modport is the scheduler view;
//                the master modport is the surrounding system view
//                (requesters, multiplier instance and result consumer).
//  Revision    : 1.0 - initial release
// ============================================================================
interface mult_share_sched_if;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [7:0] req0_op;
    logic [7:0] req1_op;
    logic [3:0] mul_m;
    logic [3:0] mul_q;
    logic [7:0] mul_p;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_p;
    logic       res_id;
    logic       busy;

    modport slave (
        input  req_valid, req0_op, req1_op, mul_p, res_ready,
        output req_ready, mul_m, mul_q, res_valid, res_p, res_id, busy
    );

    modport master (
        output req_valid, req0_op, req1_op, mul_p, res_ready,
        input  req_ready, mul_m, mul_q, res_valid, res_p, res_id, busy
    );
endinterface
`default_nettype wire

// File: rtl/mult_share_sched.sv
`default_nettype none
// ============================================================================
//  Module      : mult_share_sched
//  Description : Round-robin scheduler sharing one combinational 4x4 array
//                multiplier between two requesters. The winning operands are
//                registered onto the multiplier inputs, the product is
//                captured MULT_WAIT cycles later and returned with the
//                requester id over a valid/ready result port.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_share_sched #(
    parameter int unsigned MULT_WAIT = 1,     // legal range 1..7
    parameter bit          FIRST_PRI = 1'b0
) (
    input  wire               clk,
    input  wire               rst,
    mult_share_sched_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    localparam logic [2:0] c_WAIT_LOAD = 3'(MULT_WAIT);

    state_t     r_state_q,     w_state_d;
    logic       r_ptr_q,       w_ptr_d;
    logic [2:0] r_cnt_q,       w_cnt_d;
    logic       r_id_q,        w_id_d;
    logic [3:0] r_mul_m_q,     w_mul_m_d;
    logic [3:0] r_mul_q_q,     w_mul_q_d;
    logic [7:0] r_res_p_q,     w_res_p_d;
    logic       r_res_id_q,    w_res_id_d;
    logic       r_res_valid_q, w_res_valid_d;

    logic [1:0] w_gnt;
    logic [7:0] w_gnt_op;

    // Grant selection: only in IDLE and out of reset; a lone requester wins,
    // a tie goes to the round-robin pointer. Result is one-hot or zero.
    always_comb begin
        w_gnt = 2'b00;
        if (!rst && (r_state_q == ST_IDLE)) begin
            case (bus.req_valid)
                2'b01:   w_gnt = 2'b01;
                2'b10:   w_gnt = 2'b10;
                2'b11:   w_gnt = r_ptr_q ? 2'b10 : 2'b01;
                default: w_gnt = 2'b00;
            endcase
        end
    end

    assign w_gnt_op = w_gnt[1] ? bus.req1_op : bus.req0_op;

    // Next-state logic: accept in IDLE, count down in COMPUTE, hold the
    // result until the consumer takes it.
    always_comb begin
        w_state_d     = r_state_q;
        w_ptr_d       = r_ptr_q;
        w_cnt_d       = r_cnt_q;
        w_id_d        = r_id_q;
        w_mul_m_d     = r_mul_m_q;
        w_mul_q_d     = r_mul_q_q;
        w_res_p_d     = r_res_p_q;
        w_res_id_d    = r_res_id_q;
        w_res_valid_d = r_res_valid_q;
        case (r_state_q)
            ST_IDLE: begin
                if (|w_gnt) begin
                    w_mul_m_d = w_gnt_op[7:4];
                    w_mul_q_d = w_gnt_op[3:0];
                    w_id_d    = w_gnt[1];
                    w_ptr_d   = ~w_gnt[1];
                    w_cnt_d   = c_WAIT_LOAD;
                    w_state_d = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                w_cnt_d = r_cnt_q - 3'd1;
                if (r_cnt_q == 3'd1) begin
                    w_res_p_d     = bus.mul_p;
                    w_res_id_d    = r_id_q;
                    w_res_valid_d = 1'b1;
                    w_state_d     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.res_ready) begin
                    w_res_valid_d = 1'b0;
                    w_state_d     = ST_IDLE;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q     <= ST_IDLE;
            r_ptr_q       <= FIRST_PRI;
            r_cnt_q       <= 3'd0;
            r_id_q        <= 1'b0;
            r_mul_m_q     <= 4'd0;
            r_mul_q_q     <= 4'd0;
            r_res_p_q     <= 8'd0;
            r_res_id_q    <= 1'b0;
            r_res_valid_q <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_ptr_q       <= w_ptr_d;
            r_cnt_q       <= w_cnt_d;
            r_id_q        <= w_id_d;
            r_mul_m_q     <= w_mul_m_d;
            r_mul_q_q     <= w_mul_q_d;
            r_res_p_q     <= w_res_p_d;
            r_res_id_q    <= w_res_id_d;
            r_res_valid_q <= w_res_valid_d;
        end
    end

    assign bus.req_ready = w_gnt;
    assign bus.mul_m     = r_mul_m_q;
    assign bus.mul_q     = r_mul_q_q;
    assign bus.res_valid = r_res_valid_q;
    assign bus.res_p     = r_res_p_q;
    assign bus.res_id    = r_res_id_q;
    assign bus.busy      = (r_state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mult_share_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_share_sched
//  Description : Self-checking bench for mult_share_sched. Two instances
//                (MULT_WAIT=1 and MULT_WAIT=3) share clock and reset; each
//                has an array multiplier model on its mul_* pins. Expected
//                results are queued at accept time and popped on the
//                result handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_share_sched;

    logic clk;
    logic rst;

    mult_share_sched_if if1 ();
    mult_share_sched_if if3 ();

    mult_share_sched #(.MULT_WAIT(1), .FIRST_PRI(1'b0)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    mult_share_sched #(.MULT_WAIT(3), .FIRST_PRI(1'b0)) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (if3.slave)
    );

    // array multiplier models
    assign if1.mul_p = {4'b0000, if1.mul_m} * {4'b0000, if1.mul_q};
    assign if3.mul_p = {4'b0000, if3.mul_m} * {4'b0000, if3.mul_q};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int failed    = 0;

    logic [8:0] sb[$];   // {id, product}
    logic [8:0] exp_v;

    // snapshot of the selected DUT, taken at the negedge before an edge
    logic [1:0] s_rdy;
    logic       s_rv;
    logic [7:0] s_rp;
    logic       s_rid;
    logic       s_rr;
    logic       s_busy;
    logic [3:0] s_mm;
    logic [3:0] s_mq;

    function automatic logic [7:0] prod(input logic [7:0] op);
        return {4'b0000, op[7:4]} * {4'b0000, op[3:0]};
    endfunction

    // sample DUT at the negedge, then move past the next posedge
    task automatic samp(input bit sel);
        @(negedge clk);
        s_rdy  = sel ? if3.req_ready : if1.req_ready;
        s_rv   = sel ? if3.res_valid : if1.res_valid;
        s_rp   = sel ? if3.res_p     : if1.res_p;
        s_rid  = sel ? if3.res_id    : if1.res_id;
        s_rr   = sel ? if3.res_ready : if1.res_ready;
        s_busy = sel ? if3.busy      : if1.busy;
        s_mm   = sel ? if3.mul_m     : if1.mul_m;
        s_mq   = sel ? if3.mul_q     : if1.mul_q;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        if1.req_valid = 2'b11; if1.req0_op = 8'h12; if1.req1_op = 8'h34; if1.res_ready = 1'b0;
        if3.req_valid = 2'b00; if3.req0_op = 8'h00; if3.req1_op = 8'h00; if3.res_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if (if1.req_ready !== 2'b00) begin failed++; $display("FAIL reset_req_ready got=%b exp=00", if1.req_ready); end
        tests_run++;
        if (if1.res_valid !== 1'b0) begin failed++; $display("FAIL reset_res_valid got=%b exp=0", if1.res_valid); end
        tests_run++;
        if (if1.res_p !== 8'h00) begin failed++; $display("FAIL reset_res_p got=%h exp=00", if1.res_p); end
        tests_run++;
        if ({if1.mul_m, if1.mul_q} !== 8'h00) begin failed++; $display("FAIL reset_mul_mq got=%h exp=00", {if1.mul_m, if1.mul_q}); end
        tests_run++;
        if (if1.busy !== 1'b0) begin failed++; $display("FAIL reset_busy got=%b exp=0", if1.busy); end
        if1.req_valid = 2'b00;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_single();
        if1.req0_op = 8'hFF; if1.req_valid = 2'b01; if1.res_ready = 1'b1;
        samp(0);
        tests_run++;
        if (s_rdy !== 2'b01) begin failed++; $display("FAIL single_accept got=%b exp=01", s_rdy); end
        sb.push_back({1'b0, prod(8'hFF)});
        if1.req_valid = 2'b00;
        samp(0);
        tests_run++;
        if ({s_rv, s_busy, s_mm, s_mq} !== {1'b0, 1'b1, 8'hFF}) begin
            failed++; $display("FAIL single_compute got rv=%b busy=%b m=%h q=%h exp rv=0 busy=1 m=f q=f", s_rv, s_busy, s_mm, s_mq);
        end
        samp(0);
        tests_run++;
        if (s_rv !== 1'b1) begin failed++; $display("FAIL single_latency got=%b exp=1", s_rv); end
        else if (sb.size() == 0) begin failed++; $display("FAIL single_extra_result got id=%b p=%h exp none", s_rid, s_rp); end
        else begin
            exp_v = sb.pop_front();
            if ({s_rid, s_rp} !== exp_v) begin failed++; $display("FAIL single_result got=%h exp=%h", {s_rid, s_rp}, exp_v); end
        end
        samp(0);
        tests_run++;
        if ({s_rv, s_busy} !== 2'b00) begin failed++; $display("FAIL single_done got rv,busy=%b exp=00", {s_rv, s_busy}); end
    endtask

    task automatic test_both_valid();
        int n_acc = 0;
        int n_res = 0;
        pulse_rst();
        if1.req0_op = 8'h35; if1.req1_op = 8'h79; if1.req_valid = 2'b11; if1.res_ready = 1'b1;
        for (int c = 0; c < 40 && n_res < 2; c++) begin
            samp(0);
            if (|s_rdy) begin
                tests_run++;
                if (s_rdy !== (n_acc[0] ? 2'b10 : 2'b01)) begin
                    failed++; $display("FAIL both_grant_order got=%b exp=%b", s_rdy, n_acc[0] ? 2'b10 : 2'b01);
                end
                sb.push_back({s_rdy[1], prod(s_rdy[1] ? 8'h79 : 8'h35)});
                if1.req_valid = if1.req_valid & ~s_rdy;
                n_acc++;
            end
            if (s_rv && s_rr) begin
                tests_run++;
                if (sb.size() == 0) begin failed++; $display("FAIL both_extra_result got id=%b p=%h exp none", s_rid, s_rp); end
                else begin
                    exp_v = sb.pop_front();
                    if ({s_rid, s_rp} !== exp_v) begin failed++; $display("FAIL both_result got=%h exp=%h", {s_rid, s_rp}, exp_v); end
                end
                n_res++;
            end
        end
        tests_run++;
        if (n_res != 2) begin failed++; $display("FAIL both_count got=%0d exp=2", n_res); end
    endtask

    task automatic test_hold();
        int c = 0;
        pulse_rst();
        if1.req0_op = 8'h23; if1.req_valid = 2'b01; if1.res_ready = 1'b0;
        samp(0);
        tests_run++;
        if (s_rdy !== 2'b01) begin failed++; $display("FAIL hold_accept got=%b exp=01", s_rdy); end
        sb.push_back({1'b0, prod(8'h23)});
        if1.req1_op = 8'h11; if1.req_valid = 2'b10;
        samp(0);
        while (!s_rv && c < 10) begin samp(0); c++; end
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if ({s_rv, s_rid, s_rp, s_rdy, s_busy} !== {1'b1, 1'b0, 8'h06, 2'b00, 1'b1}) begin
                failed++;
                $display("FAIL hold_stable cyc=%0d got rv=%b id=%b p=%h rdy=%b busy=%b exp rv=1 id=0 p=06 rdy=00 busy=1",
                         i, s_rv, s_rid, s_rp, s_rdy, s_busy);
            end
            samp(0);
        end
        if1.res_ready = 1'b1;
        samp(0);
        tests_run++;
        if (!(s_rv && s_rr)) begin failed++; $display("FAIL hold_release got rv=%b exp=1", s_rv); end
        else if (sb.size() == 0) begin failed++; $display("FAIL hold_extra_result got p=%h exp none", s_rp); end
        else begin
            exp_v = sb.pop_front();
            if ({s_rid, s_rp} !== exp_v) begin failed++; $display("FAIL hold_result got=%h exp=%h", {s_rid, s_rp}, exp_v); end
        end
        samp(0);
        tests_run++;
        if ({s_busy, s_rdy} !== 3'b010) begin failed++; $display("FAIL hold_idle got busy=%b rdy=%b exp busy=0 rdy=10", s_busy, s_rdy); end
        if1.req_valid = 2'b00;
    endtask

    task automatic test_reset_compute();
        bit saw = 1'b0;
        int lat = 0;
        pulse_rst();
        if3.req0_op = 8'h44; if3.req_valid = 2'b01; if3.res_ready = 1'b1;
        samp(1);
        tests_run++;
        if (s_rdy !== 2'b01) begin failed++; $display("FAIL rstc_accept got=%b exp=01", s_rdy); end
        if3.req_valid = 2'b00;
        samp(1);
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            samp(1);
            if (s_rv) saw = 1'b1;
        end
        tests_run++;
        if (saw !== 1'b0 || s_busy !== 1'b0) begin failed++; $display("FAIL rstc_discard got rv_seen=%b busy=%b exp 0 0", saw, s_busy); end
        if3.req0_op = 8'h44; if3.req1_op = 8'h52; if3.req_valid = 2'b11;
        samp(1);
        tests_run++;
        if (s_rdy !== 2'b01) begin failed++; $display("FAIL rstc_first_pri got=%b exp=01", s_rdy); end
        sb.push_back({1'b0, prod(8'h44)});
        if3.req_valid = 2'b00;
        do begin samp(1); lat++; end while (!s_rv && lat < 12);
        tests_run++;
        if (lat != 4) begin failed++; $display("FAIL rstc_latency got=%0d exp=4", lat); end
        tests_run++;
        if (!(s_rv && s_rr) || sb.size() == 0) begin failed++; $display("FAIL rstc_result got rv=%b exp=1", s_rv); end
        else begin
            exp_v = sb.pop_front();
            if ({s_rid, s_rp} !== exp_v) begin failed++; $display("FAIL rstc_result got=%h exp=%h", {s_rid, s_rp}, exp_v); end
        end
        samp(1);
    endtask

    task automatic test_all_pairs();
        int k = 0;
        int n_res = 0;
        bit saw = 1'b0;
        pulse_rst();
        for (int c = 0; c < 20000 && n_res < 256; c++) begin
            if1.req_valid = (k < 256) ? (k[0] ? 2'b10 : 2'b01) : 2'b00;
            if1.req0_op   = k[7:0];
            if1.req1_op   = k[7:0];
            if1.res_ready = 1'($urandom_range(0, 1));
            samp(0);
            if (|s_rdy) begin
                tests_run++;
                if (s_rdy !== (k[0] ? 2'b10 : 2'b01)) begin
                    failed++; $display("FAIL pairs_grant k=%0d got=%b exp=%b", k, s_rdy, k[0] ? 2'b10 : 2'b01);
                end
                sb.push_back({k[0], prod(k[7:0])});
                k++;
            end
            if (s_rv && s_rr) begin
                tests_run++;
                if (sb.size() == 0) begin failed++; $display("FAIL pairs_extra_result got id=%b p=%h exp none", s_rid, s_rp); end
                else begin
                    exp_v = sb.pop_front();
                    if ({s_rid, s_rp} !== exp_v) begin failed++; $display("FAIL pairs_result got=%h exp=%h", {s_rid, s_rp}, exp_v); end
                end
                n_res++;
            end
        end
        if1.req_valid = 2'b00;
        if1.res_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            samp(0);
            if (s_rv) saw = 1'b1;
        end
        tests_run++;
        if (n_res != 256 || k != 256 || sb.size() != 0 || saw) begin
            failed++;
            $display("FAIL pairs_count got results=%0d accepts=%0d pending=%0d extra=%b exp 256 256 0 0", n_res, k, sb.size(), saw);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_both_valid();
        test_hold();
        test_reset_compute();
        test_all_pairs();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
